// File: rtl/mirfak_seq_divider_pkg.sv
// Shared constants and types for the mirfak iterative divider and its EX-stage requester.
package mirfak_seq_divider_pkg;

  localparam int DIV_W = 32;

  localparam logic [1:0] DIV_CMD_DIV  = 2'b00;
  localparam logic [1:0] DIV_CMD_DIVU = 2'b01;
  localparam logic [1:0] DIV_CMD_REM  = 2'b10;
  localparam logic [1:0] DIV_CMD_REMU = 2'b11;

  localparam int DIV_LATENCY = 33;

  localparam logic [DIV_W-1:0] DIV_INT_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_BUSY = 2'b01,
    DIV_DONE = 2'b10
  } div_state_e;

endpackage

// File: rtl/mirfak_seq_divider.sv
// Radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU, one quotient bit per cycle,
// with a single-cycle path for divide-by-zero and signed overflow.
module mirfak_seq_divider
  import mirfak_seq_divider_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DIV_W-1:0]  div_op1,
  input  logic [DIV_W-1:0]  div_op2,
  input  logic [1:0]        div_cmd,
  input  logic              div_enable,
  input  logic              div_abort,
  output logic [DIV_W-1:0]  div_result,
  output logic              div_ack
);

  div_state_e        state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [DIV_W-1:0]  rem_q, rem_d;
  logic [DIV_W-1:0]  quot_q, quot_d;
  logic [DIV_W-1:0]  divisor_q, divisor_d;
  logic              rem_sel_q, rem_sel_d;
  logic              q_neg_q, q_neg_d;
  logic              r_neg_q, r_neg_d;
  logic              ack_q, ack_d;
  logic [DIV_W-1:0]  result_q, result_d;

  logic              is_signed;
  logic              op1_neg;
  logic              op2_neg;
  logic [DIV_W-1:0]  abs_op1;
  logic [DIV_W-1:0]  abs_op2;
  logic              div_zero;
  logic              div_ovf;
  logic [DIV_W:0]    shifted;
  logic signed [DIV_W:0] trial;
  logic [DIV_W-1:0]  quot_nxt;
  logic [DIV_W-1:0]  rem_nxt;
  logic [DIV_W-1:0]  quot_fix;
  logic [DIV_W-1:0]  rem_fix;

  function automatic logic [DIV_W-1:0] neg32(input logic [DIV_W-1:0] v);
    return ~v + 32'd1;
  endfunction

  function automatic logic [DIV_W-1:0] cond_neg32(input logic [DIV_W-1:0] v,
                                                  input logic            neg);
    return neg ? neg32(v) : v;
  endfunction

  // Operand conditioning for the request currently presented in IDLE
  always_comb begin
    is_signed = ~div_cmd[0];
    op1_neg   = is_signed & div_op1[DIV_W-1];
    op2_neg   = is_signed & div_op2[DIV_W-1];
    abs_op1   = cond_neg32(div_op1, op1_neg);
    abs_op2   = cond_neg32(div_op2, op2_neg);
    div_zero  = (div_op2 == '0);
    div_ovf   = is_signed && (div_op1 == DIV_INT_MIN) && (div_op2 == '1);
  end

  // One restoring iteration; a negative trial means the divisor did not fit
  always_comb begin
    shifted  = {rem_q, quot_q[DIV_W-1]};
    trial    = $signed(shifted - {1'b0, divisor_q});
    quot_nxt = {quot_q[DIV_W-2:0], ~trial[DIV_W]};
    rem_nxt  = trial[DIV_W] ? shifted[DIV_W-1:0] : trial[DIV_W-1:0];
    quot_fix = cond_neg32(quot_nxt, q_neg_q);
    rem_fix  = cond_neg32(rem_nxt, r_neg_q);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quot_d    = quot_q;
    divisor_d = divisor_q;
    rem_sel_d = rem_sel_q;
    q_neg_d   = q_neg_q;
    r_neg_d   = r_neg_q;
    ack_d     = 1'b0;
    result_d  = result_q;

    case (state_q)
      DIV_IDLE: begin
        if (div_enable && !div_abort) begin
          rem_sel_d = div_cmd[1];
          q_neg_d   = op1_neg ^ op2_neg;
          r_neg_d   = op1_neg;
          divisor_d = abs_op2;
          if (div_zero) begin
            quot_d   = '1;
            rem_d    = div_op1;
            result_d = div_cmd[1] ? div_op1 : '1;
            ack_d    = 1'b1;
            state_d  = DIV_DONE;
          end else if (div_ovf) begin
            quot_d   = DIV_INT_MIN;
            rem_d    = '0;
            result_d = div_cmd[1] ? '0 : DIV_INT_MIN;
            ack_d    = 1'b1;
            state_d  = DIV_DONE;
          end else begin
            quot_d  = abs_op1;
            rem_d   = '0;
            cnt_d   = 5'd31;
            state_d = DIV_BUSY;
          end
        end
      end

      DIV_BUSY: begin
        // A dropped request is a flush as far as the divider is concerned
        if (div_abort || !div_enable) begin
          cnt_d   = '0;
          state_d = DIV_IDLE;
        end else begin
          cnt_d = cnt_q - 5'd1;
          if (cnt_q == 5'd0) begin
            quot_d   = quot_fix;
            rem_d    = rem_fix;
            result_d = rem_sel_q ? rem_fix : quot_fix;
            ack_d    = 1'b1;
            state_d  = DIV_DONE;
          end else begin
            quot_d = quot_nxt;
            rem_d  = rem_nxt;
          end
        end
      end

      DIV_DONE: begin
        state_d = DIV_IDLE;
      end

      default: begin
        state_d = DIV_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= DIV_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quot_q    <= '0;
      divisor_q <= '0;
      rem_sel_q <= 1'b0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      ack_q     <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quot_q    <= quot_d;
      divisor_q <= divisor_d;
      rem_sel_q <= rem_sel_d;
      q_neg_q   <= q_neg_d;
      r_neg_q   <= r_neg_d;
      ack_q     <= ack_d;
      result_q  <= result_d;
    end
  end

  assign div_ack    = ack_q;
  assign div_result = result_q;

endmodule

// File: tb/tb_mirfak_seq_divider.sv
// Directed bench for mirfak_seq_divider: results, latency, abort, reset and back-to-back requests.
module tb_mirfak_seq_divider;
  import mirfak_seq_divider_pkg::*;

  logic        clk;
  logic        rst;
  logic [31:0] op1;
  logic [31:0] op2;
  logic [1:0]  cmd;
  logic        en;
  logic        abort;
  logic [31:0] result;
  logic        ack;

  int checks;
  int errors;

  mirfak_seq_divider dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .div_op1    (op1),
    .div_op2    (op2),
    .div_cmd    (cmd),
    .div_enable (en),
    .div_abort  (abort),
    .div_result (result),
    .div_ack    (ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Caller is 1 time unit after a rising edge; returns the number of edges until ack (61 = none)
  task automatic wait_ack(output int edges);
    edges = 61;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (ack) begin
        edges = k;
        break;
      end
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] c, input logic [31:0] exp_res, input int exp_lat);
    int lat;
    op1 = a; op2 = b; cmd = c; en = 1'b1;
    wait_ack(lat);
    check_val({tag, " latency"}, lat, exp_lat);
    check_val({tag, " result"}, result, exp_res);
    en = 1'b0;
    @(posedge clk); #1;
    check_val({tag, " ack single"}, {31'b0, ack}, 32'd0);
  endtask

  task automatic count_acks(input int cycles, output int acks);
    acks = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (ack) acks++;
    end
  endtask

  initial begin
    int lat;
    int acks;
    checks = 0;
    errors = 0;
    rst = 1'b1; en = 1'b0; abort = 1'b0; op1 = '0; op2 = '0; cmd = '0;
    #1;
    check_val("reset ack", {31'b0, ack}, 32'd0);
    check_val("reset result", result, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    run_op("div 100/7",    32'd100,       32'd7,         DIV_CMD_DIV,  32'd14,        DIV_LATENCY);
    run_op("rem 100/7",    32'd100,       32'd7,         DIV_CMD_REM,  32'd2,         DIV_LATENCY);
    run_op("rem -100/7",   32'hFFFF_FF9C, 32'd7,         DIV_CMD_REM,  32'hFFFF_FFFE, DIV_LATENCY);
    run_op("div -100/7",   32'hFFFF_FF9C, 32'd7,         DIV_CMD_DIV,  32'hFFFF_FFF2, DIV_LATENCY);
    run_op("div 7/-2",     32'd7,         32'hFFFF_FFFE, DIV_CMD_DIV,  32'hFFFF_FFFD, DIV_LATENCY);
    run_op("rem 7/-2",     32'd7,         32'hFFFF_FFFE, DIV_CMD_REM,  32'd1,         DIV_LATENCY);
    run_op("divu max/2",   32'hFFFF_FFFF, 32'd2,         DIV_CMD_DIVU, 32'h7FFF_FFFF, DIV_LATENCY);
    run_op("remu max/2",   32'hFFFF_FFFF, 32'd2,         DIV_CMD_REMU, 32'd1,         DIV_LATENCY);
    run_op("divu min/max", 32'h8000_0000, 32'hFFFF_FFFF, DIV_CMD_DIVU, 32'd0,         DIV_LATENCY);
    run_op("div 5/0",      32'd5,         32'd0,         DIV_CMD_DIV,  32'hFFFF_FFFF, 1);
    run_op("remu 1234/0",  32'h1234,      32'd0,         DIV_CMD_REMU, 32'h1234,      1);
    run_op("rem -7/0",     32'hFFFF_FFF9, 32'd0,         DIV_CMD_REM,  32'hFFFF_FFF9, 1);
    run_op("div ovf",      32'h8000_0000, 32'hFFFF_FFFF, DIV_CMD_DIV,  32'h8000_0000, 1);
    run_op("rem ovf",      32'h8000_0000, 32'hFFFF_FFFF, DIV_CMD_REM,  32'd0,         1);

    // Abort after ten iterations
    op1 = 32'd1000; op2 = 32'd3; cmd = DIV_CMD_DIV; en = 1'b1;
    repeat (11) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0; en = 1'b0;
    check_val("abort state", 32'(dut.state_q), 32'(DIV_IDLE));
    count_acks(40, acks);
    check_val("abort no ack", acks, 32'd0);
    check_val("abort idle", 32'(dut.state_q), 32'(DIV_IDLE));
    run_op("divu 9/3", 32'd9, 32'd3, DIV_CMD_DIVU, 32'd3, DIV_LATENCY);

    // Abort beats enable in IDLE: the request only starts once abort drops
    op1 = 32'd40; op2 = 32'd8; cmd = DIV_CMD_DIVU; en = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    wait_ack(lat);
    check_val("abort+en latency", lat, DIV_LATENCY);
    check_val("abort+en result", result, 32'd5);
    en = 1'b0;
    @(posedge clk); #1;

    // Enable withdrawn mid-operation
    op1 = 32'd77; op2 = 32'd5; cmd = DIV_CMD_DIVU; en = 1'b1;
    repeat (5) @(posedge clk);
    #1 en = 1'b0;
    count_acks(40, acks);
    check_val("en drop no ack", acks, 32'd0);

    // Back-to-back: enable stays high across the ack with a new request behind it
    op1 = 32'd20; op2 = 32'd4; cmd = DIV_CMD_DIV; en = 1'b1;
    wait_ack(lat);
    check_val("b2b first latency", lat, DIV_LATENCY);
    check_val("b2b first result", result, 32'd5);
    op1 = 32'd50; op2 = 32'd5; cmd = DIV_CMD_DIVU;
    wait_ack(lat);
    check_val("b2b second latency", lat, DIV_LATENCY + 1);
    check_val("b2b second result", result, 32'd10);
    en = 1'b0;
    count_acks(40, acks);
    check_val("b2b no extra ack", acks, 32'd0);

    // Asynchronous reset in BUSY
    op1 = 32'd100; op2 = 32'd7; cmd = DIV_CMD_DIV; en = 1'b1;
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check_val("rst busy ack", {31'b0, ack}, 32'd0);
    check_val("rst busy state", 32'(dut.state_q), 32'(DIV_IDLE));
    en = 1'b0;
    @(posedge clk); #1 rst = 1'b0;

    // Asynchronous reset while ack is high
    op1 = 32'd5; op2 = 32'd0; cmd = DIV_CMD_DIV; en = 1'b1;
    @(posedge clk); #1;
    check_val("rst done ack pre", {31'b0, ack}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check_val("rst done ack", {31'b0, ack}, 32'd0);
    check_val("rst done result", result, 32'd0);
    en = 1'b0;
    @(posedge clk); #1 rst = 1'b0;

    run_op("div after rst", 32'd100, 32'd7, DIV_CMD_DIV, 32'd14, DIV_LATENCY);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
